// File: rtl/p_pipe_pkg.sv
// p_pipe_pkg: shared constants and types for the stall-capable pipeline registers.
//   DEFAULT_XLEN    default field width
//   DEFAULT_NFIELD  default number of packed fields
//   FLD_*           field index of each packed field
//   NOP_IR_DEFAULT  addi x0,x0,0, shown in the IR field of a bubble
//   pipe_state_e    occupancy of a skid stage
package p_pipe_pkg;

    localparam int unsigned DEFAULT_XLEN   = 32;
    localparam int unsigned DEFAULT_NFIELD = 5;

    localparam int unsigned FLD_PC  = 0;
    localparam int unsigned FLD_RS1 = 1;
    localparam int unsigned FLD_RS2 = 2;
    localparam int unsigned FLD_IMM = 3;
    localparam int unsigned FLD_IR  = 4;

    localparam logic [31:0] NOP_IR_DEFAULT = 32'h0000_0013;

    // EMPTY: nothing held; BUSY: main only; FULL: main and skid
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

endpackage

// File: rtl/p_sat_cnt.sv
// p_sat_cnt: saturating up-counter.
//   clk  clock, rising edge
//   rst  synchronous active-high clear
//   inc  count enable; ignored once the counter is all ones
//   cnt  current count
module p_sat_cnt #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt
);

    logic [WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/p_pipe_skid.sv
// p_pipe_skid: valid/ready pipeline register with a 2-entry skid buffer.
// Carries NFIELD packed XLEN-bit fields; field i lives at [i*XLEN +: XLEN].
//   clk        clock, rising edge
//   rst        synchronous active-high reset (drops all entries)
//   flush      drops all entries, including one offered this cycle
//   in_valid   upstream entry valid
//   in_ready   stage can accept; derived from state flops only
//   in_data    upstream packed fields
//   out_valid  main entry valid
//   out_ready  downstream accepts
//   out_data   main entry, or NOP bubble while out_valid=0
//   stall_cnt  cycles with in_valid & !in_ready (only with P_PIPE_PERF_EN)
// Optional feature macro: P_PIPE_PERF_EN adds the saturating stall counter.
module p_pipe_skid
    import p_pipe_pkg::*;
#(
    parameter int unsigned     XLEN   = p_pipe_pkg::DEFAULT_XLEN,
    parameter int unsigned     NFIELD = p_pipe_pkg::DEFAULT_NFIELD,
    parameter int unsigned     IR_IDX = p_pipe_pkg::FLD_IR,
    parameter logic [XLEN-1:0] NOP_IR = p_pipe_pkg::NOP_IR_DEFAULT
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [NFIELD*XLEN-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
`ifdef P_PIPE_PERF_EN
    output logic [NFIELD*XLEN-1:0] out_data,
    output logic [31:0]            stall_cnt
`else
    output logic [NFIELD*XLEN-1:0] out_data
`endif
);

    localparam int unsigned W = NFIELD * XLEN;

    pipe_state_e  state_q, state_d;
    logic [W-1:0] main_q, main_d;
    logic [W-1:0] skid_q, skid_d;
    logic         in_fire, out_fire;

    // Both handshake outputs come straight from the state flops.
    assign in_ready  = (state_q != FULL);
    assign out_valid = (state_q != EMPTY);
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;

    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            unique case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = BUSY;
                        main_d  = in_data;
                    end
                end
                BUSY: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = BUSY;
                        main_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data registers need no reset: they are only visible behind out_valid.
    always_ff @(posedge clk) begin
        main_q <= main_d;
        skid_q <= skid_d;
    end

    // Bubble is generated here so stale held data never leaks while invalid.
    always_comb begin
        out_data                        = '0;
        out_data[IR_IDX*XLEN +: XLEN]   = NOP_IR;
        if (out_valid) begin
            out_data = main_q;
        end
    end

`ifdef P_PIPE_PERF_EN
    p_sat_cnt #(
        .WIDTH(32)
    ) u_stall_cnt (
        .clk(clk),
        .rst(rst),
        .inc(in_valid & ~in_ready),
        .cnt(stall_cnt)
    );
`endif

endmodule

// File: tb/tb_p_pipe_skid.sv
module tb_p_pipe_skid;

    localparam int unsigned W = 160;

    logic         clk = 1'b0;
    logic         rst, flush, in_valid, out_ready;
    logic         in_ready, out_valid;
    logic [W-1:0] in_data, out_data;
`ifdef P_PIPE_PERF_EN
    logic [31:0]  stall_cnt;
    logic [31:0]  perf_model;
`endif

    int n_checks = 0;
    int n_pass   = 0;

    // Reference: a FIFO of at most two entries; bubble when empty.
    logic [W-1:0] model_q[$];
    bit           model_known = 0;
    logic [W-1:0] bubble;

    always #5 clk = ~clk;

    p_pipe_skid dut (
        .clk      (clk),
        .rst      (rst),
        .flush    (flush),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
`ifdef P_PIPE_PERF_EN
        .out_data (out_data),
        .stall_cnt(stall_cnt)
`else
        .out_data (out_data)
`endif
    );

    task automatic check_eq(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] rand_data();
        logic [W-1:0] d;
        for (int i = 0; i < 5; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    function automatic logic [W-1:0] pc_entry(input logic [31:0] pc);
        logic [W-1:0] d;
        d = rand_data();
        d[31:0] = pc;
        return d;
    endfunction

    // Drive one cycle at the falling edge, advance the model at the rising edge,
    // then compare at the next falling edge.
    task automatic step(input logic r, input logic f, input logic iv,
                        input logic [W-1:0] d, input logic ordy);
        bit space, avail;
        rst = r; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        space = (model_q.size() < 2);
        avail = (model_q.size() > 0);
        @(posedge clk);
`ifdef P_PIPE_PERF_EN
        if (r) perf_model = 0;
        else if (model_known && iv && !space && perf_model != 32'hFFFF_FFFF)
            perf_model = perf_model + 1;
`endif
        if (r || f) begin
            model_q.delete();
            if (r) model_known = 1;
        end else begin
            if (avail && ordy) void'(model_q.pop_front());
            if (iv && space) model_q.push_back(d);
        end
        @(negedge clk);
        if (model_known) begin
            check_eq("in_ready", W'(in_ready), W'(model_q.size() < 2));
            check_eq("out_valid", W'(out_valid), W'(model_q.size() > 0));
            check_eq("out_data", out_data, (model_q.size() > 0) ? model_q[0] : bubble);
`ifdef P_PIPE_PERF_EN
            check_eq("stall_cnt", W'(stall_cnt), W'(perf_model));
`endif
        end
    endtask

    initial begin
        logic [W-1:0] a, b, c;
        bubble = '0;
        bubble[159:128] = 32'h0000_0013;
`ifdef P_PIPE_PERF_EN
        perf_model = 0;
`endif
        rst = 0; flush = 0; in_valid = 0; in_data = '0; out_ready = 0;
        @(negedge clk);

        // 1. Reset with in_valid asserted
        step(1, 0, 1, rand_data(), 0);
        step(1, 0, 1, rand_data(), 0);
        check_eq("reset_bubble", out_data, {32'h13, 128'h0});
        check_eq("reset_ready", W'(in_ready), W'(1));

        // 2. Streaming with out_ready held high
        step(0, 0, 1, pc_entry(32'h00), 1);
        check_eq("stream_pc0", W'(out_data[31:0]), W'(32'h00));
        step(0, 0, 1, pc_entry(32'h04), 1);
        check_eq("stream_pc4", W'(out_data[31:0]), W'(32'h04));
        step(0, 0, 1, pc_entry(32'h08), 1);
        check_eq("stream_pc8", W'(out_data[31:0]), W'(32'h08));
        step(0, 0, 0, '0, 1);
        check_eq("stream_drained", W'(out_valid), W'(0));

        // 3. Backpressure: A then B, then release
        a = rand_data(); b = rand_data();
        step(0, 0, 1, a, 0);
        step(0, 0, 1, b, 0);
        check_eq("bp_full_ready", W'(in_ready), W'(0));
        check_eq("bp_holds_a", out_data, a);
        step(0, 0, 1, rand_data(), 0);
        check_eq("bp_stable_a", out_data, a);
        step(0, 0, 0, '0, 1);
        check_eq("bp_b_next", out_data, b);
        check_eq("bp_ready_back", W'(in_ready), W'(1));
        step(0, 0, 0, '0, 1);

        // 4. Flush in FULL while offering C
        c = rand_data();
        step(0, 0, 1, a, 0);
        step(0, 0, 1, b, 0);
        step(0, 1, 1, c, 0);
        check_eq("flush_bubble", out_data, {32'h13, 128'h0});
        check_eq("flush_ready", W'(in_ready), W'(1));
        step(0, 0, 0, '0, 1);
        check_eq("flush_no_c", W'(out_valid), W'(0));

        // 5. Flush with reset, then flush coinciding with out_fire
        step(0, 0, 1, a, 0);
        step(0, 0, 1, b, 0);
        step(1, 1, 1, c, 1);
        step(0, 0, 1, a, 0);
        step(0, 1, 0, '0, 1);
        check_eq("flush_outfire_empty", W'(out_valid), W'(0));

`ifdef P_PIPE_PERF_EN
        // 6. Stall counter: count, survive flush, saturate
        step(1, 0, 0, '0, 0);
        step(0, 0, 1, a, 0);
        step(0, 0, 1, b, 0);
        for (int i = 0; i < 10; i++) step(0, 0, 1, c, 0);
        check_eq("stall_ten", W'(stall_cnt), W'(10));
        step(0, 1, 0, '0, 0);
        check_eq("stall_kept", W'(stall_cnt), W'(10));
        force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_stall_cnt.cnt_q;
        perf_model = 32'hFFFF_FFFE;
        step(0, 0, 1, a, 0);
        step(0, 0, 1, b, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, c, 0);
        check_eq("stall_sat", W'(stall_cnt), W'(32'hFFFF_FFFF));
`endif

        // Randomized traffic against the FIFO model
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(0, 99) == 0), ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 9) < 7), rand_data(), ($urandom_range(0, 9) < 6));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/p_pipe_skid.md
Name: p_pipe_skid

Overview:
Parametrised successor to the fixed D->E pipeline register.
- Carries NFIELD packed XLEN-bit fields (default PC, rs1, rs2, Imm, IR) between any two RV32I stages.
- Adds a valid/ready handshake, a 2-entry skid buffer for full throughput with a ready derived only from state flops, synchronous flush, and NOP-bubble output when empty.
- Instantiated between IF/ID, ID/EX and EX/MEM in the new stall-capable pipeline.

Parameters:
XLEN, 32, width of one field
NFIELD, 5, number of fields; packed field i occupies bits [i*XLEN +: XLEN]
IR_IDX, 4, field index holding the instruction word
NOP_IR, 32'h00000013, instruction placed in field IR_IDX while output invalid (addi x0,x0,0)

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous, active-high reset
flush  in  1  discard all held entries (branch/jump redirect)
in_valid  in  1  upstream entry valid
in_ready  out  1  stage can accept; equals (state != FULL)
in_data  in  NFIELD*XLEN  upstream packed fields
out_valid  out  1  main entry valid
out_ready  in  1  downstream accepts
out_data  out  NFIELD*XLEN  main entry, or bubble pattern when out_valid=0
stall_cnt  out  32  only when P_PIPE_PERF_EN is defined

Behaviour:
- One clock `clk`. Reset `rst` is synchronous and active-high. No other clock or reset.
- in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Storage: main register (drives out_data) and skid register. State is EMPTY, BUSY (main only) or FULL (main+skid).
- Transitions:
  - EMPTY: in_fire -> BUSY, main<=in_data.
  - BUSY: in_fire & out_fire -> BUSY, main<=in_data.
  - BUSY: in_fire & !out_fire -> FULL, skid<=in_data.
  - BUSY: !in_fire & out_fire -> EMPTY.
  - BUSY: neither -> hold.
  - FULL: in_ready=0. out_fire -> BUSY, main<=skid. Otherwise hold.
- Latency: in_fire at edge N, visible on out_valid/out_data after edge N. Throughput 1 entry/cycle when out_ready is held high.
- in_ready depends only on the state flops; no combinational path from out_ready.
- Bubble pattern:
  - When out_valid=0, out_data is all zeros except field IR_IDX, which equals NOP_IR.
  - Produced by the output mux, not by storage. Held data is never visible while invalid.
- Ordering: entries leave in arrival order; the skid entry always follows main.
- Flush: next state EMPTY regardless of in_valid, out_ready or current state. An entry offered in the flush cycle is dropped. In_ready is 1 in the cycle after flush.
- Priority: rst > flush > handshake.
- Reset: state EMPTY, out_valid=0, out_data=bubble, in_ready=1 after the first reset edge. Reset mid-operation drops all entries identically to flush. Data registers need no reset.
- Stable-hold rule: while out_valid=1 & out_ready=0, out_data must not change.

Optional Feature:
P_PIPE_PERF_EN
- Defined:
  - stall_cnt port exists; counts cycles with in_valid & !in_ready.
  - Saturates at 32'hFFFFFFFF.
  - Cleared by rst only, not by flush.
- Undefined: port and counter are absent; the rest of the behaviour is identical.

Decomposition:
- Package p_pipe_pkg:
  - XLEN default.
  - Field index constants FLD_PC=0, FLD_RS1=1, FLD_RS2=2, FLD_IMM=3, FLD_IR=4.
  - NOP_IR constant.
  - State enum {EMPTY, BUSY, FULL}.
- Sub-module p_sat_cnt: parametrised saturating counter with clk/rst/inc. Used only under P_PIPE_PERF_EN.

Test Plan:
1. Reset: hold rst for 2 cycles with in_valid=1 -> out_valid=0, field IR=32'h00000013, other fields 0, in_ready=1, state EMPTY.
2. Streaming: out_ready=1, send PC=0x00,0x04,0x08 on consecutive cycles -> out_data PC=0x00,0x04,0x08 one cycle later each. in_ready never drops. No entry lost or duplicated.
3. Backpressure: out_ready=0, send A then B -> after 2 edges in_ready=0, out shows A. Raise out_ready -> A, then B next cycle. in_ready returns to 1 after A leaves.
4. Flush in FULL with in_valid=1 carrying C -> next cycle out_valid=0, bubble output, in_ready=1. C never appears.
5. Simultaneous flush and rst -> same result as reset. Flush on the same edge as out_fire -> EMPTY.
6. With P_PIPE_PERF_EN: hold FULL with in_valid=1 for 10 cycles -> stall_cnt=10. Flush -> stall_cnt stays 10. Preload 32'hFFFFFFFE and stall for 3 cycles -> 32'hFFFFFFFF.
